// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed 4-digit seven-segment bus: filters each digit dwell,
// inverse-decodes it and assembles 4-digit frames. Define SEVEN_SEG_CAP_SYNC_EN for a 2-flop input synchronizer.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       an,
  input  logic [6:0]       seg,
  output logic [15:0]      frame,
  output logic             frame_valid,
  output logic             frame_changed,
  output logic [CNT_W-1:0] change_cnt,
  output logic             frame_err,
  output logic             err_anode,
  output logic             err_seg
);

  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_DONE = STAB_W'(STABLE_CYCLES);
  // Idle bus: all anodes off, all (active-low) segments dark.
  localparam logic [10:0] BUS_IDLE = {4'hF, 7'h7F};

  // Inverse of the decoder table; segments active-low, seg = {g,f,e,d,c,b,a}.
  // Returns {known, code}.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b1000000: seg_decode = {1'b1, 4'h0};
      7'b1111001: seg_decode = {1'b1, 4'h1};
      7'b0100100: seg_decode = {1'b1, 4'h2};
      7'b0110000: seg_decode = {1'b1, 4'h3};
      7'b0011001: seg_decode = {1'b1, 4'h4};
      7'b0010010: seg_decode = {1'b1, 4'h5};
      7'b0000010: seg_decode = {1'b1, 4'h6};
      7'b1111000: seg_decode = {1'b1, 4'h7};
      7'b0000000: seg_decode = {1'b1, 4'h8};
      7'b0010000: seg_decode = {1'b1, 4'h9};
      7'b0001000: seg_decode = {1'b1, 4'hA};
      7'b0000011: seg_decode = {1'b1, 4'hB};
      7'b1000110: seg_decode = {1'b1, 4'hC};
      7'b0100001: seg_decode = {1'b1, 4'hD};
      7'b0000110: seg_decode = {1'b1, 4'hE};
      7'b0001110: seg_decode = {1'b1, 4'hF};
      default:    seg_decode = {1'b0, 4'hF};
    endcase
  endfunction

  logic [10:0] bus_in;

`ifdef SEVEN_SEG_CAP_SYNC_EN
  logic [10:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= BUS_IDLE;
      sync2_q <= BUS_IDLE;
    end else begin
      sync1_q <= {an, seg};
      sync2_q <= sync1_q;
    end
  end

  assign bus_in = sync2_q;
`else
  assign bus_in = {an, seg};
`endif

  logic [10:0]       samp_q, prev_q;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [3:0]        mask_q, mask_d;
  logic [3:0]        bad_q, bad_d;
  logic [3:0][3:0]   dig_q, dig_d;
  logic [15:0]       frame_q, frame_d;
  logic              frame_valid_q, frame_valid_d;
  logic              frame_changed_q, frame_changed_d;
  logic [CNT_W-1:0]  change_cnt_q, change_cnt_d;
  logic              frame_err_q, frame_err_d;
  logic              err_anode_q, err_anode_d;
  logic              err_seg_q, err_seg_d;

  logic [3:0] s_an;
  logic [6:0] s_seg;
  logic [3:0] an_low;
  logic       one_low;
  logic       accept;
  logic       complete;
  logic [4:0] dec;

  assign s_an    = samp_q[10:7];
  assign s_seg   = samp_q[6:0];
  assign an_low  = ~s_an;
  assign one_low = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
  assign dec     = seg_decode(s_seg);

  // NOTE: every always_comb output gets a default first, so no path can leave a latch.
  always_comb begin
    stab_d          = 1'b1;
    mask_d          = mask_q;
    bad_d           = bad_q;
    dig_d           = dig_q;
    frame_d         = frame_q;
    frame_valid_d   = 1'b0;
    frame_changed_d = 1'b0;
    change_cnt_d    = change_cnt_q;
    frame_err_d     = frame_err_q;
    err_anode_d     = 1'b0;
    err_seg_d       = 1'b0;

    // Counter parks at STAB_DONE so a long dwell yields a single accept.
    if (samp_q == prev_q) begin
      stab_d = (stab_q == STAB_DONE) ? stab_q : stab_q + 1'b1;
    end
    accept = (stab_d == STAB_DONE) && (stab_q != STAB_DONE);

    complete = (mask_q == 4'hF);
    if (complete) begin
      mask_d        = 4'd0;
      bad_d         = 4'd0;
      frame_d       = dig_q;
      frame_valid_d = 1'b1;
      frame_err_d   = |bad_q;
      // frame_q doubles as the previous-frame register.
      if (dig_q != frame_q) begin
        frame_changed_d = 1'b1;
        if (change_cnt_q != {CNT_W{1'b1}}) begin
          change_cnt_d = change_cnt_q + 1'b1;
        end
      end
    end

    if (accept && (an_low != 4'd0)) begin
      if (one_low) begin
        for (int i = 0; i < 4; i++) begin
          if (an_low[i]) begin
            dig_d[i]  = dec[3:0];
            mask_d[i] = 1'b1;
            bad_d[i]  = ~dec[4];
          end
        end
        err_seg_d = ~dec[4];
      end else begin
        err_anode_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  // NOTE: the per-digit registers are reset too, so a frame can never expose stale digits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q          <= BUS_IDLE;
      prev_q          <= BUS_IDLE;
      stab_q          <= '0;
      mask_q          <= 4'd0;
      bad_q           <= 4'd0;
      dig_q           <= '0;
      frame_q         <= 16'd0;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
      change_cnt_q    <= '0;
      frame_err_q     <= 1'b0;
      err_anode_q     <= 1'b0;
      err_seg_q       <= 1'b0;
    end else begin
      samp_q          <= bus_in;
      prev_q          <= samp_q;
      stab_q          <= stab_d;
      mask_q          <= mask_d;
      bad_q           <= bad_d;
      dig_q           <= dig_d;
      frame_q         <= frame_d;
      frame_valid_q   <= frame_valid_d;
      frame_changed_q <= frame_changed_d;
      change_cnt_q    <= change_cnt_d;
      frame_err_q     <= frame_err_d;
      err_anode_q     <= err_anode_d;
      err_seg_q       <= err_seg_d;
    end
  end

  assign frame         = frame_q;
  assign frame_valid   = frame_valid_q;
  assign frame_changed = frame_changed_q;
  assign change_cnt    = change_cnt_q;
  assign frame_err     = frame_err_q;
  assign err_anode     = err_anode_q;
  assign err_seg       = err_seg_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: table of whole-frame vectors plus
// hand-written reset, glitch, anode-error and mid-frame-reset sequences.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  an  = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] frame;
  logic        frame_valid, frame_changed, frame_err, err_anode, err_seg;
  logic [7:0]  change_cnt;

  seven_seg_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .frame(frame), .frame_valid(frame_valid), .frame_changed(frame_changed),
    .change_cnt(change_cnt), .frame_err(frame_err),
    .err_anode(err_anode), .err_seg(err_seg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Pulse monitor, sampled on the falling edge.
  int valid_seen = 0, changed_seen = 0, anode_seen = 0, seg_seen = 0;
  always @(negedge clk) begin
    if (frame_valid)   valid_seen++;
    if (frame_changed) changed_seen++;
    if (err_anode)     anode_seen++;
    if (err_seg)       seg_seen++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Forward decoder encoding (active-low, {g,f,e,d,c,b,a}).
  function automatic logic [6:0] enc(input logic [3:0] c);
    case (c)
      4'h0: enc = 7'h40; 4'h1: enc = 7'h79; 4'h2: enc = 7'h24; 4'h3: enc = 7'h30;
      4'h4: enc = 7'h19; 4'h5: enc = 7'h12; 4'h6: enc = 7'h02; 4'h7: enc = 7'h78;
      4'h8: enc = 7'h00; 4'h9: enc = 7'h10; 4'hA: enc = 7'h08; 4'hB: enc = 7'h03;
      4'hC: enc = 7'h46; 4'hD: enc = 7'h21; 4'hE: enc = 7'h06; default: enc = 7'h0E;
    endcase
  endfunction

  localparam logic [6:0] BAD_SEG = 7'h55;

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_digit(input int i, input logic [6:0] s, input int n);
    logic [3:0] a;
    a    = 4'hF;
    a[i] = 1'b0;
    drive(a, s, n);
  endtask

  task automatic send_frame(input logic [15:0] codes, input logic [3:0] bad, input int hold);
    for (int i = 0; i < 4; i++) begin
      drive_digit(i, bad[i] ? BAD_SEG : enc(codes[i*4 +: 4]), hold);
    end
    drive(4'hF, 7'h7F, 8);
  endtask

  typedef struct {
    logic [15:0] codes;
    int          hold;
    logic [3:0]  bad;
    logic [15:0] exp_frame;
    logic        exp_changed;
    logic        exp_err;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[11];
  int v0, c0, a0, s0;
  logic bad_rst;

  initial begin
    vecs[0]  = '{16'h4321, 8, 4'b0000, 16'h4321, 1'b1, 1'b0, 1};
    vecs[1]  = '{16'h4321, 8, 4'b0000, 16'h4321, 1'b0, 1'b0, 1};
    vecs[2]  = '{16'h5432, 8, 4'b0000, 16'h5432, 1'b1, 1'b0, 2};
    vecs[3]  = '{16'h5432, 4, 4'b0000, 16'h5432, 1'b0, 1'b0, 2};
    vecs[4]  = '{16'h0000, 5, 4'b0000, 16'h0000, 1'b1, 1'b0, 3};
    vecs[5]  = '{16'h0000, 4, 4'b0000, 16'h0000, 1'b0, 1'b0, 3};
    vecs[6]  = '{16'hFEDC, 6, 4'b0000, 16'hFEDC, 1'b1, 1'b0, 4};
    vecs[7]  = '{16'hBA98, 4, 4'b0000, 16'hBA98, 1'b1, 1'b0, 5};
    vecs[8]  = '{16'h7654, 4, 4'b0100, 16'h7F54, 1'b1, 1'b1, 6};
    vecs[9]  = '{16'h7654, 4, 4'b0000, 16'h7654, 1'b1, 1'b0, 7};
    vecs[10] = '{16'h7654, 4, 4'b0000, 16'h7654, 1'b0, 1'b0, 7};

    // Reset held while the bus toggles: outputs must stay cleared.
    bad_rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      drive_digit(k % 4, enc(4'(k)), 2);
      if ({frame, frame_valid, frame_changed, change_cnt, frame_err, err_anode, err_seg} != '0)
        bad_rst = 1'b1;
    end
    check("reset_hold_outputs", 32'(bad_rst), 32'd0);
    drive(4'hF, 7'h7F, 1);
    rst = 1'b1;
    drive(4'hF, 7'h7F, 20);
    check("post_reset_pulses", 32'(valid_seen + changed_seen + anode_seen + seg_seen), 32'd0);
    check("post_reset_frame", 32'(frame), 32'd0);
    check("post_reset_cnt", 32'(change_cnt), 32'd0);

    for (int v = 0; v < 11; v++) begin
      v0 = valid_seen; c0 = changed_seen; s0 = seg_seen;
      send_frame(vecs[v].codes, vecs[v].bad, vecs[v].hold);
      check($sformatf("v%0d_valid_pulses", v), 32'(valid_seen - v0), 32'd1);
      check($sformatf("v%0d_frame", v), 32'(frame), 32'(vecs[v].exp_frame));
      check($sformatf("v%0d_changed", v), 32'(changed_seen - c0), 32'(vecs[v].exp_changed));
      check($sformatf("v%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_change_cnt", v), 32'(change_cnt), 32'(vecs[v].exp_cnt));
      check($sformatf("v%0d_err_seg", v), 32'(seg_seen - s0), 32'($countones(vecs[v].bad)));
    end

    // Dwells of 3 cycles fall short of the filter.
    v0 = valid_seen;
    for (int i = 0; i < 4; i++) drive_digit(i, enc(4'(i + 1)), 3);
    drive(4'hF, 7'h7F, 8);
    check("glitch_no_valid", 32'(valid_seen - v0), 32'd0);
    check("glitch_frame_kept", 32'(frame), 32'h7654);
    send_frame(16'h1234, 4'b0000, 4);
    check("hold4_valid", 32'(valid_seen - v0), 32'd1);
    check("hold4_frame", 32'(frame), 32'h1234);
    check("hold4_cnt", 32'(change_cnt), 32'd8);

    // Two anodes low for 6 cycles: one error pulse, nothing captured.
    v0 = valid_seen; a0 = anode_seen;
    drive(4'b1100, enc(4'h6), 6);
    drive(4'hF, 7'h7F, 8);
    check("anode_err_pulses", 32'(anode_seen - a0), 32'd1);
    check("anode_no_valid", 32'(valid_seen - v0), 32'd0);
    // A 3-digit follow-up must not complete a frame if the bad dwell wrote nothing.
    for (int i = 1; i < 4; i++) drive_digit(i, enc(4'h2), 8);
    drive(4'hF, 7'h7F, 8);
    check("anode_no_capture", 32'(valid_seen - v0), 32'd0);
    drive_digit(0, enc(4'h2), 8);
    drive(4'hF, 7'h7F, 8);
    check("anode_then_frame", 32'(frame), 32'h2222);

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 3; i++) drive_digit(i, enc(4'(9 - i)), 8);
    rst = 1'b0;
    drive(4'hF, 7'h7F, 3);
    check("midreset_frame", 32'(frame), 32'd0);
    check("midreset_cnt", 32'(change_cnt), 32'd0);
    rst = 1'b1;
    drive(4'hF, 7'h7F, 4);
    v0 = valid_seen; c0 = changed_seen;
    drive_digit(3, enc(4'hA), 8);
    drive_digit(2, enc(4'hB), 8);
    drive_digit(1, enc(4'hC), 8);
    drive(4'hF, 7'h7F, 8);
    check("midreset_no_early_valid", 32'(valid_seen - v0), 32'd0);
    drive_digit(0, enc(4'hD), 8);
    drive(4'hF, 7'h7F, 8);
    check("midreset_valid", 32'(valid_seen - v0), 32'd1);
    check("midreset_new_frame", 32'(frame), 32'hABCD);
    check("midreset_changed", 32'(changed_seen - c0), 32'd1);
    check("midreset_cnt_after", 32'(change_cnt), 32'd1);
    check("midreset_frame_err", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
